// File: rtl/victory_pkg.sv
// Shared types and constants for the tug-of-war match scorekeeper.
package victory_pkg;

    // Round/match control states.
    typedef enum logic [1:0] {
        PLAY    = 2'd0,
        RESTART = 2'd1,
        OVER    = 2'd2
    } state_t;

    // Winner encodings as seen on the winner output.
    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

    // Largest target score that still fits one decimal digit on the HEX display.
    localparam int SCORE_MAX = 9;

endpackage

// File: rtl/score_counter.sv
// Four-bit round-win counter with synchronous clear and increment.
// Saturation is handled by the controller, which only increments in PLAY.
module score_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       clr,
    output logic [3:0] count
);

    // Clear wins over increment so a new match always starts from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc) begin
            count <= count + 4'd1;
        end
    end

endmodule

// File: rtl/seg7.sv
// Active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
// Values above 9 blank the display.
module seg7 (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pure lookup from digit to segment pattern.
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'd0: seg = 7'b1000000;
            4'd1: seg = 7'b1111001;
            4'd2: seg = 7'b0100100;
            4'd3: seg = 7'b0110000;
            4'd4: seg = 7'b0011001;
            4'd5: seg = 7'b0010010;
            4'd6: seg = 7'b0000010;
            4'd7: seg = 7'b1111000;
            4'd8: seg = 7'b0000000;
            4'd9: seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/match_scorekeeper.sv
// Round and match scorekeeper for the two-player tug-of-war game.
// A round is won when a player presses while their edge light is lit.
// Non-final rounds pulse round_restart for one cycle; the final point
// freezes the match in OVER until new_match is requested.
// Handshake note: press_l, press_r and new_match are single-cycle strobes
// with no backpressure; round_restart is a single-cycle strobe to the
// playfield, also without backpressure.
module match_scorekeeper
    import victory_pkg::*;
#(
    parameter int WIN_SCORE = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       edge_l,
    input  logic       edge_r,
    input  logic       press_l,
    input  logic       press_r,
    input  logic       new_match,
    output logic       round_restart,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r
);

    // The score must fit a single decimal digit.
    generate
        if (WIN_SCORE < 1 || WIN_SCORE > SCORE_MAX) begin : g_bad_win_score
            $error("match_scorekeeper: WIN_SCORE must be within 1..9");
        end
    endgenerate

    localparam logic [3:0] WIN_VAL = 4'(WIN_SCORE);

    state_t     state;
    state_t     state_next;
    logic       qual_l;
    logic       qual_r;
    logic       final_l;
    logic       final_r;
    logic       inc_l;
    logic       inc_r;
    logic       clr;
    logic [1:0] winner_next;

    assign qual_l  = edge_l & press_l;
    assign qual_r  = edge_r & press_r;
    assign final_l = ((score_l + 4'd1) == WIN_VAL);
    assign final_r = ((score_r + 4'd1) == WIN_VAL);

    // State and winner registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= PLAY;
            winner <= WIN_NONE;
        end else begin
            state  <= state_next;
            winner <= winner_next;
        end
    end

    // Next state: new_match overrides everything and recentres the playfield.
    always_comb begin
        state_next = state;
        if (new_match) begin
            state_next = RESTART;
        end else begin
            case (state)
                PLAY: begin
                    if (qual_l && !qual_r) begin
                        state_next = final_l ? OVER : RESTART;
                    end else if (qual_r && !qual_l) begin
                        state_next = final_r ? OVER : RESTART;
                    end else if (qual_l && qual_r) begin
                        state_next = RESTART;
                    end
                end
                RESTART: state_next = PLAY;
                OVER:    state_next = OVER;
                default: state_next = PLAY;
            endcase
        end
    end

    // Outputs: counter controls, next winner and the restart strobe.
    always_comb begin
        clr           = new_match;
        inc_l         = !new_match && (state == PLAY) && qual_l && !qual_r;
        inc_r         = !new_match && (state == PLAY) && qual_r && !qual_l;
        round_restart = (state == RESTART);
        winner_next   = winner;
        if (new_match) begin
            winner_next = WIN_NONE;
        end else if (inc_l && final_l) begin
            winner_next = WIN_L;
        end else if (inc_r && final_r) begin
            winner_next = WIN_R;
        end
    end

    score_counter u_score_l (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_l),
        .clr   (clr),
        .count (score_l)
    );

    score_counter u_score_r (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_r),
        .clr   (clr),
        .count (score_r)
    );

    seg7 u_hex_l (
        .digit (score_l),
        .seg   (hex_l)
    );

    seg7 u_hex_r (
        .digit (score_r),
        .seg   (hex_r)
    );

endmodule

// File: tb/tb_match_scorekeeper.sv
// Bench for match_scorekeeper: one instance at the default target of 7,
// one at a target of 3. Expected outputs are pushed when a stimulus row
// is driven and popped for comparison one edge later.
module tb_match_scorekeeper;

    // Stimulus rows packed as {edge_l, edge_r, press_l, press_r, new_match}.
    localparam logic [4:0] S_I  = 5'b00000;
    localparam logic [4:0] S_L  = 5'b10100;
    localparam logic [4:0] S_R  = 5'b01010;
    localparam logic [4:0] S_B  = 5'b11110;
    localparam logic [4:0] S_NM = 5'b00001;

    // Clock and reset.
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    logic el_a, er_a, pl_a, pr_a, nm_a;
    logic el_b, er_b, pl_b, pr_b, nm_b;
    logic       rr_a, rr_b;
    logic [3:0] sl_a, sr_a, sl_b, sr_b;
    logic [1:0] win_a, win_b;
    logic [6:0] hl_a, hr_a, hl_b, hr_b;

    logic [24:0] obs_a, obs_b;
    assign obs_a = {rr_a, win_a, sl_a, sr_a, hl_a, hr_a};
    assign obs_b = {rr_b, win_b, sl_b, sr_b, hl_b, hr_b};

    int n_checks = 0;
    int n_fail   = 0;
    logic [24:0] exp_q[$];

    match_scorekeeper dut_a (
        .clk(clk), .reset(reset),
        .edge_l(el_a), .edge_r(er_a), .press_l(pl_a), .press_r(pr_a), .new_match(nm_a),
        .round_restart(rr_a), .score_l(sl_a), .score_r(sr_a), .winner(win_a),
        .hex_l(hl_a), .hex_r(hr_a)
    );

    match_scorekeeper #(.WIN_SCORE(3)) dut_b (
        .clk(clk), .reset(reset),
        .edge_l(el_b), .edge_r(er_b), .press_l(pl_b), .press_r(pr_b), .new_match(nm_b),
        .round_restart(rr_b), .score_l(sl_b), .score_r(sr_b), .winner(win_b),
        .hex_l(hl_b), .hex_r(hr_b)
    );

    // Reference seven-segment table, active low {g..a}.
    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Build an expected observation vector.
    function automatic logic [24:0] mk(input logic rr, input logic [1:0] w,
                                       input logic [3:0] sl, input logic [3:0] sr);
        return {rr, w, sl, sr, seg_ref(sl), seg_ref(sr)};
    endfunction

    // Driver: apply one row to the selected DUT, queue its expectation, advance one edge.
    task automatic drive(input bit sel_b, input logic [4:0] stim, input logic [24:0] exp);
        if (sel_b) {el_b, er_b, pl_b, pr_b, nm_b} = stim;
        else       {el_a, er_a, pl_a, pr_a, nm_a} = stim;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [4:0]  st [9];
        logic [24:0] ex [9];
        logic [24:0] got, want;
        reset = 1'b0;
        {el_a, er_a, pl_a, pr_a, nm_a} = S_I;
        {el_b, er_b, pl_b, pr_b, nm_b} = S_I;
        repeat (2) @(posedge clk);
        #1;
        // Presses while reset is low must be ignored.
        drive(1'b0, S_L, mk(1'b0, 2'b00, 4'd0, 4'd0));
        got = obs_a; want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL reset_hold got=%h want=%h", got, want); end
        got = obs_b; n_checks++;
        if (got !== mk(1'b0, 2'b00, 4'd0, 4'd0)) begin n_fail++; $display("FAIL reset_b got=%h want=%h", got, mk(1'b0, 2'b00, 4'd0, 4'd0)); end
        reset = 1'b1;
        // Build up to 3-2, ending in a restart cycle.
        st = '{S_L, S_I, S_R, S_I, S_L, S_I, S_R, S_I, S_L};
        ex = '{mk(1, 0, 1, 0), mk(0, 0, 1, 0), mk(1, 0, 1, 1), mk(0, 0, 1, 1),
               mk(1, 0, 2, 1), mk(0, 0, 2, 1), mk(1, 0, 2, 2), mk(0, 0, 2, 2),
               mk(1, 0, 3, 2)};
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, st[i], ex[i]);
            got = obs_a; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL reset_build[%0d] got=%h want=%h", i, got, want); end
        end
        // Asynchronous assertion between edges.
        {el_a, er_a, pl_a, pr_a, nm_a} = S_I;
        reset = 1'b0;
        #1;
        got = obs_a; n_checks++;
        if (got !== mk(1'b0, 2'b00, 4'd0, 4'd0)) begin n_fail++; $display("FAIL reset_async got=%h want=%h", got, mk(1'b0, 2'b00, 4'd0, 4'd0)); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        drive(1'b0, S_I, mk(1'b0, 2'b00, 4'd0, 4'd0));
        got = obs_a; want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin n_fail++; $display("FAIL reset_release got=%h want=%h", got, want); end
        n_checks++;
        if (hl_a !== 7'b1000000 || hr_a !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_hex got=%b/%b want=1000000/1000000", hl_a, hr_a);
        end
    endtask

    task automatic test_right_point();
        logic [4:0]  st [3];
        logic [24:0] ex [3];
        logic [24:0] got, want;
        st = '{S_R, S_R, S_I};
        ex = '{mk(1, 0, 0, 1), mk(0, 0, 0, 1), mk(0, 0, 0, 1)};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, st[i], ex[i]);
            got = obs_a; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL right_point[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    task automatic test_no_qualify();
        logic [4:0]  st [6];
        logic [24:0] got, want;
        st = '{5'b00100, 5'b10000, 5'b10000, 5'b00010, 5'b01100, 5'b10010};
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, st[i], mk(1'b0, 2'b00, 4'd0, 4'd1));
            got = obs_a; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL no_qualify[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    task automatic test_tie();
        logic [4:0]  st [4];
        logic [24:0] ex [4];
        logic [24:0] got, want;
        st = '{S_L, S_I, S_B, S_I};
        ex = '{mk(1, 0, 1, 1), mk(0, 0, 1, 1), mk(1, 0, 1, 1), mk(0, 0, 1, 1)};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, st[i], ex[i]);
            got = obs_a; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL tie[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    // From 1-1 to a 7-4 left win, then a new match from OVER.
    task automatic test_new_match_over();
        logic [4:0]  st[$];
        logic [24:0] ex[$];
        logic [24:0] got, want;
        logic [3:0]  el, er;
        el = 4'd1; er = 4'd1;
        for (int k = 0; k < 3; k++) begin
            er++;
            st.push_back(S_R); ex.push_back(mk(1'b1, 2'b00, el, er));
            st.push_back(S_I); ex.push_back(mk(1'b0, 2'b00, el, er));
        end
        for (int k = 0; k < 5; k++) begin
            el++;
            st.push_back(S_L); ex.push_back(mk(1'b1, 2'b00, el, er));
            st.push_back(S_I); ex.push_back(mk(1'b0, 2'b00, el, er));
        end
        st.push_back(S_L);  ex.push_back(mk(1'b0, 2'b01, 4'd7, 4'd4));
        st.push_back(S_L);  ex.push_back(mk(1'b0, 2'b01, 4'd7, 4'd4));
        st.push_back(S_R);  ex.push_back(mk(1'b0, 2'b01, 4'd7, 4'd4));
        st.push_back(S_B);  ex.push_back(mk(1'b0, 2'b01, 4'd7, 4'd4));
        st.push_back(S_NM); ex.push_back(mk(1'b1, 2'b00, 4'd0, 4'd0));
        st.push_back(S_I);  ex.push_back(mk(1'b0, 2'b00, 4'd0, 4'd0));
        st.push_back(S_R);  ex.push_back(mk(1'b1, 2'b00, 4'd0, 4'd1));
        st.push_back(S_I);  ex.push_back(mk(1'b0, 2'b00, 4'd0, 4'd1));
        // new_match beats a qualifying press in the same cycle.
        st.push_back(S_L | S_NM); ex.push_back(mk(1'b1, 2'b00, 4'd0, 4'd0));
        st.push_back(S_I);  ex.push_back(mk(1'b0, 2'b00, 4'd0, 4'd0));
        for (int i = 0; i < st.size(); i++) begin
            drive(1'b0, st[i], ex[i]);
            got = obs_a; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL new_match_over[%0d] got=%h want=%h", i, got, want); end
        end
    endtask

    // Target of 3 on the second instance: third left point ends the match.
    task automatic test_win3();
        logic [4:0]  st [9];
        logic [24:0] ex [9];
        logic [24:0] got, want;
        st = '{S_L, S_I, S_L, S_I, S_L, S_L, S_I, S_R, S_B};
        ex = '{mk(1, 0, 1, 0), mk(0, 0, 1, 0), mk(1, 0, 2, 0), mk(0, 0, 2, 0),
               mk(0, 1, 3, 0), mk(0, 1, 3, 0), mk(0, 1, 3, 0), mk(0, 1, 3, 0),
               mk(0, 1, 3, 0)};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, st[i], ex[i]);
            got = obs_b; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin n_fail++; $display("FAIL win3[%0d] got=%h want=%h", i, got, want); end
        end
        {el_b, er_b, pl_b, pr_b, nm_b} = S_I;
    endtask

    initial begin
        test_reset();
        test_right_point();
        test_no_qualify();
        test_tie();
        test_new_match_over();
        test_win3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
